aes_result_collector: RTL and testbench

Output stage directly downstream of aes_engine. Captures every out_packet_t the engine emits (valid pulses, no backpressure into the engine) into a circular buffer and presents results to the host in strict order over a valid/ready handshake. Drives a hold signal that the input-side FIFO read enable is gated with, so in-flight engine results never overflow the buffer. Overflow is detected and counted, never silent.

---
 rtl/aes_result_collector_pkg.sv | 18 +
 rtl/aes_result_collector.sv | 118 +++++++++++
 tb/tb_aes_result_collector.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_result_collector_pkg.sv
// Shared AES datapath types: engine result packet and stored result entry.
package aes_result_collector_pkg;

  localparam int unsigned AES_DATA_W = 128;
  localparam int unsigned AES_RES_W  = 129;

  typedef struct packed {
    logic [AES_DATA_W-1:0] data;
    logic                  en_de;
    logic                  valid;
  } out_packet_t;

  typedef struct packed {
    logic [AES_DATA_W-1:0] data;
    logic                  en_de;
  } res_entry_t;

endpackage

// File: rtl/aes_result_collector.sv
// Circular result buffer behind aes_engine with FWFT host handshake, hold and drop accounting.
// Optional AES_OUT_STATS_EN adds saturating encrypt/decrypt result counters.
module aes_result_collector
  import aes_result_collector_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned HOLD_MARGIN = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  out_packet_t             data_in,
  input  logic                    flush,
  output logic [AES_DATA_W-1:0]   out_data,
  output logic                    out_en_de,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    hold,
  output logic                    overflow,
  output logic [7:0]              drop_cnt,
`ifdef AES_OUT_STATS_EN
  output logic [31:0]             enc_cnt,
  output logic [31:0]             dec_cnt,
`endif
  input  logic                    clr_overflow
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned HOLD_LVL = DEPTH - HOLD_MARGIN;

  res_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  res_entry_t       head;

  logic push_req;
  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // Status decoded straight from the registered count.
  assign out_valid = (count != '0);
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign hold      = (count >= CNT_W'(HOLD_LVL));

  assign push_req = data_in.valid;
  assign pop      = out_valid & out_ready;
  assign push     = push_req & (~full | pop);
  assign wr_en    = push & ~flush;
  // A push discarded by flush is not a drop.
  assign drop     = push_req & ~push & ~flush;

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.data  : '0;
  assign out_en_de = out_valid ? head.en_de : 1'b0;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= res_entry_t'{data: data_in.data, en_de: data_in.en_de};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Drop in the same cycle as clr_overflow restarts the tally at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)           drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

`ifdef AES_OUT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      dec_cnt <= '0;
    end else if (flush) begin
      enc_cnt <= '0;
      dec_cnt <= '0;
    end else if (push) begin
      if (data_in.en_de) begin
        if (enc_cnt != 32'hFFFF_FFFF) enc_cnt <= enc_cnt + 32'd1;
      end else begin
        if (dec_cnt != 32'hFFFF_FFFF) dec_cnt <= dec_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed self-checking bench for aes_result_collector (DEPTH=32, HOLD_MARGIN=12).
module tb_aes_result_collector;
  import aes_result_collector_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  out_packet_t  data_in;
  logic         flush;
  logic [127:0] out_data;
  logic         out_en_de;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   count;
  logic         full;
  logic         empty;
  logic         hold;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic         clr_overflow;
`ifdef AES_OUT_STATS_EN
  logic [31:0]  enc_cnt;
  logic [31:0]  dec_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  aes_result_collector #(.DEPTH(32), .HOLD_MARGIN(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .flush        (flush),
    .out_data     (out_data),
    .out_en_de    (out_en_de),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .hold         (hold),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
`ifdef AES_OUT_STATS_EN
    .enc_cnt      (enc_cnt),
    .dec_cnt      (dec_cnt),
`endif
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic e);
    data_in = '{data: d, en_de: e, valid: v};
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".count"},     128'(count),     128'd0);
    chk({tag, ".empty"},     128'(empty),     128'd1);
    chk({tag, ".full"},      128'(full),      128'd0);
    chk({tag, ".hold"},      128'(hold),      128'd0);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, ".out_data"},  out_data,        128'd0);
    chk({tag, ".out_en_de"}, 128'(out_en_de), 128'd0);
    chk({tag, ".overflow"},  128'(overflow),  128'd0);
    chk({tag, ".drop_cnt"},  128'(drop_cnt),  128'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    drive(1'b0, 128'd0, 1'b0);
    #12;
    chk_reset_state("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Three results in, head visible one cycle after the first write
    drive(1'b1, 128'h01, 1'b1);
    tick();
    chk("fwft.valid", 128'(out_valid), 128'd1);
    chk("fwft.data",  out_data,        128'h01);
    drive(1'b1, 128'h02, 1'b0);
    tick();
    drive(1'b1, 128'h03, 1'b1);
    tick();
    drive(1'b0, 128'd0, 1'b0);
    chk("abc.count", 128'(count),     128'd3);
    chk("abc.valid", 128'(out_valid), 128'd1);
    chk("abc.head",  out_data,        128'h01);
    tick();
    chk("abc.stable", out_data, 128'h01);
    out_ready = 1'b1;
    chk("pop.a.en", 128'(out_en_de), 128'd1);
    tick();
    chk("pop.b",    out_data,        128'h02);
    chk("pop.b.en", 128'(out_en_de), 128'd0);
    tick();
    chk("pop.c",    out_data,        128'h03);
    chk("pop.c.en", 128'(out_en_de), 128'd1);
    tick();
    out_ready = 1'b0;
    chk("drained.valid", 128'(out_valid), 128'd0);
    chk("drained.empty", 128'(empty),     128'd1);
    chk("drained.data",  out_data,        128'd0);

    // Fill 32 with no host; hold threshold at 20
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 128'h100 + 128'(i), i[0]);
      tick();
      chk($sformatf("fill.hold%0d", i + 1), 128'(hold), 128'((i + 1) >= 20));
    end
    chk("fill.full",  128'(full),  128'd1);
    chk("fill.count", 128'(count), 128'd32);
    drive(1'b1, 128'hDEAD, 1'b1);
    tick();
    drive(1'b0, 128'd0, 1'b0);
    chk("ovf.flag",  128'(overflow), 128'd1);
    chk("ovf.cnt",   128'(drop_cnt), 128'd1);
    chk("ovf.count", 128'(count),    128'd32);
    chk("ovf.head",  out_data,       128'h100);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr.flag", 128'(overflow), 128'd0);
    chk("clr.cnt",  128'(drop_cnt), 128'd0);

    // Full with simultaneous pop accepts the push
    drive(1'b1, 128'hAA, 1'b0);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 128'd0, 1'b0);
    chk("fullpop.count", 128'(count),    128'd32);
    chk("fullpop.ovf",   128'(overflow), 128'd0);
    chk("fullpop.head",  out_data,       128'h101);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("drain%0d", k), out_data, (k < 31) ? 128'h101 + 128'(k) : 128'hAA);
      tick();
    end
    out_ready = 1'b0;
    chk("drain.empty", 128'(empty), 128'd1);

    // Refill, then drop coincident with clr_overflow
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 128'h200 + 128'(i), 1'b0);
      tick();
    end
    drive(1'b1, 128'hBAD, 1'b0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("dropclr.flag", 128'(overflow), 128'd1);
    chk("dropclr.cnt",  128'(drop_cnt), 128'd1);
    tick();
    chk("drop2.cnt", 128'(drop_cnt), 128'd2);

    // Flush while full with a push: no drop, counters untouched
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 128'd0, 1'b0);
    chk("flushfull.count", 128'(count),     128'd0);
    chk("flushfull.valid", 128'(out_valid), 128'd0);
    chk("flushfull.drop",  128'(drop_cnt),  128'd2);
    chk("flushfull.ovf",   128'(overflow),  128'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr2.flag", 128'(overflow), 128'd0);
    chk("clr2.cnt",  128'(drop_cnt), 128'd0);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 128'h300 + 128'(i), 1'b1);
      tick();
    end
    chk("five.count", 128'(count), 128'd5);
    drive(1'b1, 128'h3FF, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush5.count", 128'(count),     128'd0);
    chk("flush5.valid", 128'(out_valid), 128'd0);
    chk("flush5.drop",  128'(drop_cnt),  128'd0);
    drive(1'b1, 128'h77, 1'b0);
    tick();
    drive(1'b0, 128'd0, 1'b0);
    chk("postflush.valid", 128'(out_valid), 128'd1);
    chk("postflush.data",  out_data,        128'h77);
    chk("postflush.count", 128'(count),     128'd1);

`ifdef AES_OUT_STATS_EN
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stats.flushed", 128'(enc_cnt), 128'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 128'h400 + 128'(i), (i < 5));
      tick();
    end
    drive(1'b0, 128'd0, 1'b0);
    chk("stats.enc", 128'(enc_cnt), 128'd5);
    chk("stats.dec", 128'(dec_cnt), 128'd2);
`endif

    // Asynchronous reset mid-stream, sampled before the next edge
    drive(1'b1, 128'h55, 1'b1);
    tick();
    drive(1'b1, 128'h56, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
`ifdef AES_OUT_STATS_EN
    chk("midrst.enc", 128'(enc_cnt), 128'd0);
    chk("midrst.dec", 128'(dec_cnt), 128'd0);
`endif
    drive(1'b0, 128'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("afterrst.empty", 128'(empty), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
